// File: rtl/des_sbox_pipe.sv
// rtl/des_sbox_pipe.sv - pipelined DES S-box substitution stage with valid/ready handshake
// Key XOR plus all eight S-boxes; one or two register stages with full backpressure.
module des_sbox_pipe #(
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  input  logic [47:0]      in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] xfer_count
);

  // Indexed [sbox][row][column]; each 64-bit word is one table row, column 0 in the top nibble.
  localparam logic [0:7][0:3][0:15][3:0] SBOX = {
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  function automatic logic [31:0] sboxLookup(input logic [47:0] x);
    logic [47:0] rest;
    logic [5:0]  f;
    logic [2:0]  lane;
    logic [31:0] res;
    rest = x;
    lane = '0;
    res  = '0;
    for (int i = 0; i < 8; i++) begin
      f    = rest[47:42];
      res  = {res[27:0], SBOX[lane][{f[5], f[0]}][f[4:1]]};
      rest = rest << 6;
      lane = lane + 3'd1;
    end
    return res;
  endfunction

  logic             feedValid;
  logic [47:0]      feedXor;
  logic             outLoad;
  logic             outValidQ;
  logic [31:0]      outDataQ;
  logic [CNT_W-1:0] countQ;

  // The output stage refills whenever it is empty or draining this cycle.
  assign outLoad = feedValid && (!outValidQ || out_ready);

  generate
    if (PIPE_DEPTH == 1) begin : gDirect
      assign feedValid = in_valid;
      assign feedXor   = in_data ^ in_key;
      assign in_ready  = !outValidQ || out_ready;
    end else begin : gStaged
      logic        s1Valid;
      logic [47:0] s1Xor;

      assign in_ready  = !s1Valid || outLoad;
      assign feedValid = s1Valid;
      assign feedXor   = s1Xor;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1Valid <= 1'b0;
          s1Xor   <= '0;
        end else if (in_ready) begin
          s1Valid <= in_valid;
          if (in_valid) s1Xor <= in_data ^ in_key;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      outDataQ  <= '0;
    end else if (outLoad) begin
      outValidQ <= 1'b1;
      outDataQ  <= sboxLookup(feedXor);
    end else if (out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) countQ <= '0;
    else if (outValidQ && out_ready) countQ <= countQ + CNT_W'(1);
  end

  assign out_valid  = outValidQ;
  assign out_data   = outDataQ;
  assign xfer_count = countQ;

endmodule

// File: tb/tb_des_sbox_pipe.sv
// tb/tb_des_sbox_pipe.sv - directed bench for des_sbox_pipe at PIPE_DEPTH 1 and 2
// Index 0 drives the depth-1 instance, index 1 the depth-2 instance; both use a 4-bit counter.
module tb_des_sbox_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN = 1'b0;
  logic        inValid   [2];
  logic        inReady   [2];
  logic [47:0] inData    [2];
  logic [47:0] inKey     [2];
  logic        outValid  [2];
  logic        outReady  [2];
  logic [31:0] outData   [2];
  logic [3:0]  xferCount [2];

  int checks = 0;
  int errors = 0;

  localparam logic [47:0] KEY = 48'h5A5AC3C39696;
  localparam logic [47:0] VDATA [6] = '{48'h0, 48'hFFFFFFFFFFFF, 48'h0, 48'h000000001000,
                                        48'h000000005000, 48'h00000003F000};
  localparam logic [47:0] VKEY  [6] = '{48'h0, 48'h0, 48'hFFFFFFFFFFFF, 48'h0, 48'h0, 48'h0};
  localparam logic [31:0] VEXP  [6] = '{32'hEFA72C4D, 32'hD9CE3DCB, 32'hD9CE3DCB, 32'hEFA72A4D,
                                        32'hEFA7244D, 32'hEFA72D4D};

  // Standard DES tables, row-major: entry = row*16 + column.
  int tbS [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  des_sbox_pipe #(.PIPE_DEPTH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rstN),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]), .in_key(inKey[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .xfer_count(xferCount[0])
  );

  des_sbox_pipe #(.PIPE_DEPTH(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rstN),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]), .in_key(inKey[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .xfer_count(xferCount[1])
  );

  // Same 6-bit value v in every lane.
  function automatic logic [31:0] model(input logic [5:0] v);
    logic [31:0] res;
    int idx;
    res = '0;
    idx = int'({v[5], v[0]}) * 16 + int'(v[4:1]);
    for (int i = 0; i < 8; i++) res = {res[27:0], 4'(tbS[i][idx])};
    return res;
  endfunction

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      inValid[k]  = 1'b0;
      outReady[k] = 1'b0;
      inData[k]   = '0;
      inKey[k]    = '0;
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset(input int d);
    doReset();
    #1;
    checks++; if (outValid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid d=%0d got %b want 0", d, outValid[d]); end
    checks++; if (outData[d] !== 32'h0) begin errors++; $display("FAIL reset_out_data d=%0d got %h want 00000000", d, outData[d]); end
    checks++; if (xferCount[d] !== 4'h0) begin errors++; $display("FAIL reset_count d=%0d got %0d want 0", d, xferCount[d]); end
    checks++; if (inReady[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready d=%0d got %b want 1", d, inReady[d]); end
  endtask

  task automatic test_vectors(input int d);
    int depth = d + 1;
    doReset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      inValid[d] = 1'b1; inData[d] = VDATA[k]; inKey[d] = VKEY[k]; outReady[d] = 1'b1;
      #1;
      checks++; if (inReady[d] !== 1'b1) begin errors++; $display("FAIL vec_in_ready d=%0d k=%0d got %b want 1", d, k, inReady[d]); end
      for (int j = 1; j <= depth; j++) begin
        @(negedge clk);
        inValid[d] = 1'b0;
        #1;
        checks++;
        if (outValid[d] !== (j == depth)) begin
          errors++; $display("FAIL vec_latency d=%0d k=%0d cyc=%0d got %b want %b", d, k, j, outValid[d], (j == depth));
        end
      end
      checks++; if (outData[d] !== VEXP[k]) begin errors++; $display("FAIL vec_data d=%0d k=%0d got %h want %h", d, k, outData[d], VEXP[k]); end
      @(negedge clk);
      #1;
      checks++; if (xferCount[d] !== 4'(k + 1)) begin errors++; $display("FAIL vec_count d=%0d k=%0d got %0d want %0d", d, k, xferCount[d], k + 1); end
      checks++; if (outValid[d] !== 1'b0) begin errors++; $display("FAIL vec_drain d=%0d k=%0d got %b want 0", d, k, outValid[d]); end
    end
  endtask

  // Streams n beats (lane value b*mul+add); stall applies out_ready pattern 1,0,0,1.
  task automatic test_stream(input int d, input string name, input int n, input int mul, input int add, input bit stall);
    logic [31:0] expQ [$];
    logic [31:0] held = '0;
    logic [5:0]  v;
    bit heldV = 1'b0;
    int depth = d + 1;
    int sent = 0, recv = 0, cyc = 0, occ;
    for (int b = 0; b < n; b++) expQ.push_back(model(6'(b * mul + add)));
    doReset();
    while (recv < n && cyc < n * 6 + 20) begin
      @(negedge clk);
      outReady[d] = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      inValid[d]  = (sent < n);
      v = 6'(sent * mul + add);
      inData[d] = {8{v}} ^ KEY;
      inKey[d]  = KEY;
      #1;
      occ = sent - recv;
      checks++;
      if (inReady[d] !== !(occ == depth && !outReady[d])) begin
        errors++; $display("FAIL %s_in_ready d=%0d cyc=%0d got %b want %b", name, d, cyc, inReady[d], !(occ == depth && !outReady[d]));
      end
      if (heldV) begin
        checks++;
        if (outValid[d] !== 1'b1 || outData[d] !== held) begin
          errors++; $display("FAIL %s_hold d=%0d cyc=%0d got %b/%h want 1/%h", name, d, cyc, outValid[d], outData[d], held);
        end
      end
      heldV = outValid[d] && !outReady[d];
      held  = outData[d];
      if (outValid[d] && outReady[d]) begin
        checks++;
        if (outData[d] !== expQ[recv]) begin
          errors++; $display("FAIL %s_data d=%0d beat=%0d got %h want %h", name, d, recv, outData[d], expQ[recv]);
        end
        recv++;
      end
      if (inValid[d] && inReady[d]) sent++;
      cyc++;
    end
    checks++; if (recv != n) begin errors++; $display("FAIL %s_timeout d=%0d got %0d beats want %0d", name, d, recv, n); end
    @(negedge clk);
    inValid[d] = 1'b0; outReady[d] = 1'b0;
    #1;
    checks++; if (xferCount[d] !== 4'(n)) begin errors++; $display("FAIL %s_count d=%0d got %0d want %0d", name, d, xferCount[d], n % 16); end
    checks++; if (outValid[d] !== 1'b0) begin errors++; $display("FAIL %s_extra d=%0d got %b want 0", name, d, outValid[d]); end
  endtask

  task automatic test_reset_midstream(input int d);
    doReset();
    @(negedge clk);
    outReady[d] = 1'b0; inValid[d] = 1'b1; inData[d] = {8{6'd7}} ^ KEY; inKey[d] = KEY;
    @(negedge clk);
    inData[d] = {8{6'd9}} ^ KEY;
    #1;
    checks++; if (outValid[d] !== (d == 0)) begin errors++; $display("FAIL mid_fill d=%0d got %b want %b", d, outValid[d], (d == 0)); end
    @(negedge clk);
    rstN = 1'b0; inValid[d] = 1'b0;
    #1;
    checks++; if (outValid[d] !== 1'b1) begin errors++; $display("FAIL mid_inflight d=%0d got %b want 1", d, outValid[d]); end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++; if (outValid[d] !== 1'b0) begin errors++; $display("FAIL mid_out_valid d=%0d got %b want 0", d, outValid[d]); end
    checks++; if (xferCount[d] !== 4'h0) begin errors++; $display("FAIL mid_count d=%0d got %0d want 0", d, xferCount[d]); end
    checks++; if (inReady[d] !== 1'b1) begin errors++; $display("FAIL mid_in_ready d=%0d got %b want 1", d, inReady[d]); end
    outReady[d] = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      #1;
      checks++; if (outValid[d] !== 1'b0) begin errors++; $display("FAIL mid_stale d=%0d cyc=%0d got %b want 0", d, j, outValid[d]); end
    end
    checks++; if (xferCount[d] !== 4'h0) begin errors++; $display("FAIL mid_count_after d=%0d got %0d want 0", d, xferCount[d]); end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      inValid[k] = 1'b0; outReady[k] = 1'b0; inData[k] = '0; inKey[k] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      test_reset(d);
      test_vectors(d);
      test_stream(d, "backpressure", 8, 9, 3, 1'b1);
      test_stream(d, "exhaustive", 64, 1, 0, 1'b0);
      test_reset_midstream(d);
      test_stream(d, "wrap", 17, 5, 1, 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_sbox_pipe.md
# des_sbox_pipe

Pipelined DES round-function substitution stage: XORs a 48-bit expanded half-block with a 48-bit round subkey, applies all eight DES S-boxes in parallel, and delivers the 32-bit result. It replaces the single-S-box combinational lookup blocks in the DES datapath with one parametrised unit. The unit has a configurable pipeline depth, a valid/ready handshake with full backpressure, and a wrapping transfer counter. It sits between the E-expansion and the P-permutation of each round.

## Interface
- PIPE_DEPTH, default 2: number of register stages from input to output; legal values 1 or 2.
- CNT_W, default 16: width of the completed-transfer counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  in_data/in_key valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_data  in  48  expanded half-block, S1 field at [47:42] … S8 field at [5:0].
- in_key  in  48  round subkey, same field layout.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  32  S-box outputs concatenated, S1 nibble at [31:28] … S8 nibble at [3:0].
- xfer_count  out  CNT_W  number of completed output transfers, modulo 2^CNT_W.

## Operation
- Lane i (S1..S8) computes x = in_data[47-6i -: 6] ^ in_key[47-6i -: 6] and looks up the standard DES Si table.
- The table index is the raw 6-bit x: row = {x[5],x[0]}, column = x[4:1]. This matches the existing S-box lookup blocks. For example, S6(0)=12, S6(1)=10, S6(5)=4, S6(63)=13.
- PIPE_DEPTH=1:
  - XOR and lookup are combinational.
  - The result is registered into the output stage.
- PIPE_DEPTH=2:
  - Stage 1 registers the 48-bit XOR result and a valid bit.
  - Stage 2 registers the lookup result.
- Each stage holds a valid bit. A stage loads when it is empty or when its contents move downstream in the same cycle.
- in_ready = !s1_valid || s1_advance. This is a combinational path from out_ready through the pipeline; it is accepted.
- Data is accepted on in_valid && in_ready. The output transfers on out_valid && out_ready.
- Beats leave in acceptance order. No beat is dropped or duplicated, and bubbles collapse when downstream stalls.
- xfer_count increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (rst_n=0 at a rising edge): all stage valid bits = 0, out_valid=0, out_data=0, xfer_count=0.
- in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats and does not count them.
- Latency from accept to out_valid is PIPE_DEPTH cycles with no stall. For example, a beat accepted on edge N has out_valid=1 after edge N+PIPE_DEPTH-1+1.
- Throughput is one beat per cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - out_data is held stable.
  - The unit accepts up to PIPE_DEPTH-1 further beats into empty upper stages, then deasserts in_ready.
- Simultaneous output transfer and input accept on a full pipeline: both complete in the same cycle and occupancy is unchanged.
- in_data/in_key are don't-care when in_valid=0. out_data is don't-care when out_valid=0 (except at reset, where it is 0).
- No combinational path from in_data to out_data for either depth.

## Test plan
- Zero vector: data=0, key=0, one beat, out_ready=1 -> out_data=32'hEFA72C4D after PIPE_DEPTH cycles; xfer_count=1.
- All ones: data=48'hFFFFFFFFFFFF, key=0 -> 32'hD9CE3DCB. Then data=0, key=48'hFFFFFFFFFFFF -> 32'hD9CE3DCB.
- S6 isolation: data=48'h000000001000 (S6 field=1), key=0 -> 32'hEFA72A4D (S6 nibble=4'hA).
- Backpressure: stream 8 distinct beats with out_ready toggled 1,0,0,1,… -> all 8 results emerge in order, unchanged while stalled, none lost; in_ready=0 only when the pipeline is full and stalled; xfer_count=8.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> next cycle out_valid=0, xfer_count=0, in_ready=1; no stale beat appears afterwards.
- Counter wrap (CNT_W=4): 17 transfers -> xfer_count=1.
- Run every scenario at PIPE_DEPTH=1 and PIPE_DEPTH=2.
- Exhaustive lane check: all 64 values of each field against the DES tables via a model.
